hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one 4-bit-to-7-segment hex decoder between NUM_DIGITS common-anode digit positions.
- Latches a multi-digit value through a shadow register and steps a digit index at a programmable refresh rate.
- Drives the shared decoder's 4-bit input, a segment-blank qualifier and active-low digit selects.
- Sits between the datapath (counters, registers under display) and the board's display pins.

Parameters:
- NUM_DIGITS, 4, digit positions scanned; legal range 2..8.
- TICKS_PER_DIGIT, 50000, clk cycles per digit slot; minimum 4.
- LZ_BLANK, 1, 1 enables leading-zero blanking; 0 shows all digits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures value.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k = value[4k+3:4k] shown on digit k; digit 0 is least significant.
- dec_digit  out  4  nibble fed to the shared hex decoder.
- dec_blank  out  1  1 = force all segments off (segments 7'b1111111 at top level).
- digit_sel  out  NUM_DIGITS  active-low digit enables; at most one bit low.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently driven.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (cycle after reset sampled high):
  - prescaler = 0, idx = 0, active = 0, pending = 0, pend_valid = 0.
  - dec_digit = 0, dec_blank = 1, digit_sel = all ones, digit_idx = 0, frame_done = 0.
- Reset asserted mid-scan or mid-load takes effect on the next edge. Any in-flight pending value is discarded.
- Prescaler:
  - Counts 0..TICKS_PER_DIGIT-1.
  - At terminal count: wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the terminal-count cycle with idx = NUM_DIGITS-1.
  - frame_done = 1 for exactly the one cycle after the boundary edge.
- Shadow load (tear-free):
  - load=1 captures value into pending and sets pend_valid.
  - At a frame boundary, if pend_valid: active <= pending, pend_valid <= 0.
  - If load coincides with a frame boundary, the new value goes directly to active and pend_valid stays 0.
  - Multiple loads within one frame: the last one wins.
- Outputs are registered, one cycle after the state they reflect.
  - Anti-ghost dead time: when prescaler = 0, digit_sel = all ones and dec_blank = 1.
  - Otherwise digit_sel has bit idx low, dec_digit = active nibble idx, and digit_idx = idx.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k>0 has dec_blank=1 if nibbles k..NUM_DIGITS-1 of active are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - With LZ_BLANK=0, dec_blank=0 outside dead time.
- Width rules: idx and prescaler are unsigned. The prescaler width is sized from TICKS_PER_DIGIT. No overflow is possible beyond the wrap points above.

Optional Feature:
- Macro: HEX_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask (NUM_DIGITS bits) and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles blink_phase every BLINK_FRAMES frame boundaries. blink_phase resets to 0 (visible).
  - While blink_phase = 1, digits with a set blink_mask bit get dec_blank = 1; digit_sel timing is unchanged.
  - blink_mask is sampled live, not shadowed.
- Not defined: no blink_mask port, no frame counter; behaviour exactly as above.

Test Plan (NUM_DIGITS=4, TICKS_PER_DIGIT=4, LZ_BLANK=1 unless noted):
- Reset, then release with no load -> digit_sel sequence 1111,1110,1110,1110,1111,1101... Digit 0 shows dec_digit=0, dec_blank=0; digits 1-3 have dec_blank=1. frame_done pulses every 16 cycles.
- load value=16'h0A3F mid-frame -> display unchanged until the next frame_done. Then digits 0..2 show F,3,A; digit 3 is blanked.
- load 16'h1234 then 16'h5678 within one frame -> the next frame shows 8,7,6,5; 1234 is never displayed.
- load asserted on the frame-boundary cycle with 16'hBEEF -> the immediately following frame shows F,E,E,B; pend_valid stays 0.
- LZ_BLANK=0, value 16'h0000 -> all four digits show 0 with dec_blank=0 outside dead time. Reset asserted mid-frame -> all outputs return to reset values on the next cycle.
- HEX_SCAN_BLINK_EN defined, BLINK_FRAMES=2, blink_mask=4'b0010, value 16'h1111 -> digit 1 is blanked in frames 2-3 and visible in frames 0-1 and 4-5; other digits are always visible.

Source files
------------

// File: rtl/hex_scan_if.sv
// Display-side bus of hex_scan_ctrl: value loading plus decoder/digit-select outputs.
// HEX_SCAN_BLINK_EN adds the live per-digit blink_mask input.
interface hex_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  localparam int IW = $clog2(NUM_DIGITS);

  // Handshake: there is no ready; load is a single-cycle strobe that is always accepted,
  // value is sampled on the same rising edge, and no backpressure exists.
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [3:0]              dec_digit;
  logic                    dec_blank;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [IW-1:0]           digit_idx;
  logic                    frame_done;
`ifdef HEX_SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;

  modport master (
    output load, value, blink_mask,
    input  dec_digit, dec_blank, digit_sel, digit_idx, frame_done
  );

  modport slave (
    input  load, value, blink_mask,
    output dec_digit, dec_blank, digit_sel, digit_idx, frame_done
  );
`else
  modport master (
    output load, value,
    input  dec_digit, dec_blank, digit_sel, digit_idx, frame_done
  );

  modport slave (
    input  load, value,
    output dec_digit, dec_blank, digit_sel, digit_idx, frame_done
  );
`endif
endinterface

// File: rtl/hex_scan_ctrl.sv
// Multiplexed common-anode hex display scanner with tear-free shadow loading.
// Optional blink support is compiled in with HEX_SCAN_BLINK_EN.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int LZ_BLANK        = 1
`ifdef HEX_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES    = 64
`endif
) (
  input logic       clk,
  input logic       reset,
  hex_scan_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(TICKS_PER_DIGIT);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [3:0]            dec_digit_q, dec_digit_d;
  logic                  dec_blank_q, dec_blank_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  dead_time;
  logic                  higher_nz;
  logic                  lz_hide;
  logic                  blink_hide;

`ifdef HEX_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
`endif

  always_comb begin
    slot_end  = (presc_q == PRESC_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    dead_time = (presc_q == '0);

    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Active only changes at a frame boundary so a scan never mixes two values.
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    if (frame_end) begin
      if (bus.load) begin
        active_d = bus.value;
      end else if (pend_valid_q) begin
        active_d = pending_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pending_d    = bus.value;
      pend_valid_d = 1'b1;
    end

    higher_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (active_q[4*j +: 4] != 4'h0)) begin
        higher_nz = 1'b1;
      end
    end
    lz_hide = (LZ_BLANK != 0) && (idx_q != '0) && !higher_nz;

`ifdef HEX_SCAN_BLINK_EN
    blink_hide    = blink_phase_q && bus.blink_mask[idx_q];
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
`else
    blink_hide = 1'b0;
`endif

    // Slot start is a dead cycle so the previous digit's segments never ghost onto the next.
    digit_sel_d  = dead_time ? '1 : ~(ONE_HOT0 << idx_q);
    dec_blank_d  = dead_time || lz_hide || blink_hide;
    dec_digit_d  = active_q[{idx_q, 2'b00} +: 4];
    digit_idx_d  = idx_q;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pend_valid_q  <= 1'b0;
      dec_digit_q   <= 4'h0;
      dec_blank_q   <= 1'b1;
      digit_sel_q   <= '1;
      digit_idx_q   <= '0;
      frame_done_q  <= 1'b0;
`ifdef HEX_SCAN_BLINK_EN
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pend_valid_q  <= pend_valid_d;
      dec_digit_q   <= dec_digit_d;
      dec_blank_q   <= dec_blank_d;
      digit_sel_q   <= digit_sel_d;
      digit_idx_q   <= digit_idx_d;
      frame_done_q  <= frame_done_d;
`ifdef HEX_SCAN_BLINK_EN
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign bus.dec_digit  = dec_digit_q;
  assign bus.dec_blank  = dec_blank_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.digit_idx  = digit_idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: one LZ_BLANK=1 and one LZ_BLANK=0 instance driven in lockstep,
// compared each cycle against an arithmetic model of the scan timeline.
module tb_hex_scan_ctrl;
  localparam int ND = 4;
  localparam int T  = 4;
  localparam int FR = ND * T;
  localparam int BF = 2;
  localparam int W  = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blink_mask;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [15:0] act_m;
  logic [15:0] pend_m;
  bit          pv_m;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  hex_scan_if #(.NUM_DIGITS(ND)) bus_lz ();
  hex_scan_if #(.NUM_DIGITS(ND)) bus_nolz ();

  assign bus_lz.load    = load;
  assign bus_lz.value   = value;
  assign bus_nolz.load  = load;
  assign bus_nolz.value = value;

`ifdef HEX_SCAN_BLINK_EN
  assign bus_lz.blink_mask   = blink_mask;
  assign bus_nolz.blink_mask = blink_mask;

  hex_scan_ctrl #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(T), .LZ_BLANK(1), .BLINK_FRAMES(BF)) u_dut_lz (
    .clk(clk), .reset(reset), .bus(bus_lz)
  );
  hex_scan_ctrl #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(T), .LZ_BLANK(0), .BLINK_FRAMES(BF)) u_dut_nolz (
    .clk(clk), .reset(reset), .bus(bus_nolz)
  );
`else
  hex_scan_ctrl #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(T), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .reset(reset), .bus(bus_lz)
  );
  hex_scan_ctrl #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(T), .LZ_BLANK(0)) u_dut_nolz (
    .clk(clk), .reset(reset), .bus(bus_nolz)
  );
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word: {frame_done, blank_lz, blank_nolz, data_valid, sel[3:0], digit[3:0], idx[1:0]}
  task automatic model_edge();
    int          presc;
    int          idx;
    int          frame;
    bit          dead;
    bit          lzb;
    bit          nolzb;
    bit          fd;
    logic [15:0] shifted;
    logic [3:0]  sel;
    logic [1:0]  idx2;
    if (reset) begin
      exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 2'd0});
      n      = 0;
      act_m  = 16'h0;
      pend_m = 16'h0;
      pv_m   = 1'b0;
    end else begin
      presc   = n % T;
      idx     = (n / T) % ND;
      frame   = n / FR;
      dead    = (presc == 0);
      shifted = act_m >> (4 * idx);
      lzb     = dead || ((idx != 0) && (shifted == 16'h0));
      nolzb   = dead;
`ifdef HEX_SCAN_BLINK_EN
      if (!dead && (((frame / BF) % 2) == 1) && blink_mask[idx]) begin
        lzb   = 1'b1;
        nolzb = 1'b1;
      end
`else
      if (frame < 0) lzb = 1'b1;
`endif
      sel  = 4'b0001 << idx;
      sel  = dead ? 4'hF : ~sel;
      idx2 = idx[1:0];
      fd   = (((n + 1) % FR) == 0);
      exp_q.push_back({fd, lzb, nolzb, !dead, sel, shifted[3:0], idx2});
      if (fd) begin
        if (load) act_m = value;
        else if (pv_m) act_m = pend_m;
        pv_m = 1'b0;
      end else if (load) begin
        pend_m = value;
        pv_m   = 1'b1;
      end
      n++;
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      chk("lz_digit_sel",    {4'h0, bus_lz.digit_sel},    {4'h0, e[9:6]});
      chk("lz_dec_blank",    {7'h0, bus_lz.dec_blank},    {7'h0, e[12]});
      chk("lz_frame_done",   {7'h0, bus_lz.frame_done},   {7'h0, e[13]});
      chk("nolz_digit_sel",  {4'h0, bus_nolz.digit_sel},  {4'h0, e[9:6]});
      chk("nolz_dec_blank",  {7'h0, bus_nolz.dec_blank},  {7'h0, e[11]});
      chk("nolz_frame_done", {7'h0, bus_nolz.frame_done}, {7'h0, e[13]});
      if (e[10]) begin
        chk("lz_dec_digit",   {4'h0, bus_lz.dec_digit},   {4'h0, e[5:2]});
        chk("lz_digit_idx",   {6'h0, bus_lz.digit_idx},   {6'h0, e[1:0]});
        chk("nolz_dec_digit", {4'h0, bus_nolz.dec_digit}, {4'h0, e[5:2]});
        chk("nolz_digit_idx", {6'h0, bus_nolz.digit_idx}, {6'h0, e[1:0]});
      end
    end
  endtask

  // Drives inputs at the falling edge, models the rising edge, checks at the next falling edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] v);
    reset = r;
    load  = ld;
    value = v;
    if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> (4 * $urandom_range(0, 4));
  endfunction

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    value      = 16'h0;
    blink_mask = 4'b0010;
    n          = 0;
    act_m      = 16'h0;
    pend_m     = 16'h0;
    pv_m       = 1'b0;
    @(negedge clk);

    repeat (3) step(1'b1, 1'b0, 16'($urandom));
    repeat (2 * FR) step(1'b0, 1'b0, 16'($urandom));

    while ((n % FR) != 5) step(1'b0, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'h0A3F);
    repeat (2 * FR) step(1'b0, 1'b0, 16'($urandom));

    while ((n % FR) != 2) step(1'b0, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'h1234);
    repeat (4) step(1'b0, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'h5678);
    repeat (2 * FR) step(1'b0, 1'b0, 16'($urandom));

    while (((n + 1) % FR) != 0) step(1'b0, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'hBEEF);
    repeat (2 * FR) step(1'b0, 1'b0, 16'($urandom));

    step(1'b0, 1'b1, 16'h0000);
    repeat (2 * FR) step(1'b0, 1'b0, 16'($urandom));

    repeat (600) step(1'b0, ($urandom_range(0, 7) == 0), rand_value());

    while ((n % FR) != 9) step(1'b0, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, 16'h00C0);
    step(1'b1, 1'b0, 16'($urandom));
    repeat (2 * FR) step(1'b0, ($urandom_range(0, 5) == 0), rand_value());

    repeat (400) step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), rand_value());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
